// File: rtl/instr_fetch_seq_if.sv
// instr_fetch_seq_if: instruction memory request/ack/rvalid bus
interface instr_fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: PC owner that fetches, holds and retires one instruction at a time
module instr_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_seq_if.master  imem,
  output logic [31:0]        ins,
  output logic               ins_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               branchEnable,
  input  logic               branch_taken,
  input  logic [31:0]        rs_data,
  output logic               link_we,
  output logic [31:0]        link_data,
  output logic [31:0]        pc
);
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ins_q, ins_d, pc4, br_tgt, next_pc;
  logic        ins_valid_q, ins_valid_d, is_jal, retire;
  assign pc4            = pc_q + 32'd4;
  assign br_tgt         = pc4 + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
  assign is_jal         = ins_q[31:26] == 6'b000011;
  assign retire         = state_q == ISSUE && exec_done;
  assign next_pc        = jump ? (is_jal ? {pc4[31:28], ins_q[25:0], 2'b00} : {rs_data[31:2], 2'b00})
                        : (branchEnable && branch_taken) ? br_tgt : pc4;
  assign imem.imem_req  = rst_n && state_q == FETCH;
  assign imem.imem_addr = pc_q;
  assign link_we        = rst_n && retire && jump && is_jal;
  assign link_data      = pc4;
  assign pc             = pc_q;
  assign ins            = ins_q;
  assign ins_valid      = ins_valid_q;
  // next-state: capture the word when it arrives, advance the PC when execute retires it
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    case (state_q)
      FETCH: if (imem.imem_ack) begin
        state_d     = imem.imem_rvalid ? ISSUE : WAIT;
        ins_d       = imem.imem_rvalid ? imem.imem_rdata : ins_q;
        ins_valid_d = imem.imem_rvalid;
      end
      WAIT: if (imem.imem_rvalid) begin
        state_d     = ISSUE;
        ins_d       = imem.imem_rdata;
        ins_valid_d = 1'b1;
      end
      ISSUE: if (exec_done) begin
        state_d     = FETCH;
        pc_d        = next_pc;
        ins_valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed self-checking bench for instr_fetch_seq
module tb_instr_fetch_seq;
  logic        clk = 0, rst_n = 0;
  logic [31:0] ins, link_data, pc, rs_data;
  logic        ins_valid, exec_done, jump, branchEnable, branch_taken, link_we;
  int          checks = 0, errors = 0;
  instr_fetch_seq_if bus ();
  instr_fetch_seq #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master), .ins(ins), .ins_valid(ins_valid),
    .exec_done(exec_done), .jump(jump), .branchEnable(branchEnable), .branch_taken(branch_taken),
    .rs_data(rs_data), .link_we(link_we), .link_data(link_data), .pc(pc));
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.imem_ack = 0; bus.imem_rvalid = 0; exec_done = 0;
    jump = 0; branchEnable = 0; branch_taken = 0;
  endtask
  task automatic fetch_issue(input logic [31:0] w);
    bus.imem_ack = 1; bus.imem_rvalid = 1; bus.imem_rdata = w;
    cyc();
    bus.imem_ack = 0; bus.imem_rvalid = 0;
  endtask
  task automatic retire_jr(input logic [31:0] tgt);
    fetch_issue(32'h0000_0008);
    rs_data = tgt; jump = 1; exec_done = 1;
    cyc();
    idle();
  endtask
  task automatic test_reset;
    rst_n = 0; idle(); bus.imem_rdata = 0; rs_data = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid got %0b want 0", ins_valid); end
      checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL reset_link_we got %0b want 0", link_we); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", bus.imem_req); end
    end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h want 00000100", pc); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins got %h want 0", ins); end
    rst_n = 1;
    cyc();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr got %h want 00000100", bus.imem_addr); end
  endtask
  task automatic test_seq_delay;
    cyc();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL held_req got %0b want 1", bus.imem_req); end
    bus.imem_ack = 1;
    cyc();
    bus.imem_ack = 0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got %0b want 0", bus.imem_req); end
    cyc();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL wait_valid got %0b want 0", ins_valid); end
    bus.imem_rvalid = 1; bus.imem_rdata = 32'h8000_0000;
    cyc();
    bus.imem_rvalid = 0;
    checks++; if (ins !== 32'h8000_0000) begin errors++; $display("FAIL seq_ins got %h want 80000000", ins); end
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %0b want 1", ins_valid); end
    exec_done = 1;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL seq_link_we got %0b want 0", link_we); end
    cyc();
    idle();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_fall got %0b want 0", ins_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin errors++; $display("FAIL seq_next got req %0b addr %h want 1 00000104", bus.imem_req, bus.imem_addr); end
  endtask
  task automatic test_jr_priority;
    fetch_issue(32'h2000_0000);
    rs_data = 32'h203; jump = 1; branchEnable = 1; branch_taken = 1; exec_done = 1;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jr_link_we got %0b want 0", link_we); end
    cyc();
    idle();
    checks++; if (pc !== 32'h200 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL jr_pc got %h want 00000200", pc); end
  endtask
  task automatic test_bleu;
    fetch_issue(32'h1000_FFFE);
    branchEnable = 1; branch_taken = 1; exec_done = 1;
    cyc();
    idle();
    checks++; if (pc !== 32'h1FC) begin errors++; $display("FAIL bleu_taken got %h want 000001fc", pc); end
    fetch_issue(32'h0000_0000);
    exec_done = 1;
    cyc();
    idle();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL bleu_seq got %h want 00000200", pc); end
    fetch_issue(32'h1000_FFFE);
    branchEnable = 1; branch_taken = 0; exec_done = 1;
    cyc();
    idle();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL bleu_not_taken got %h want 00000204", pc); end
    retire_jr(32'hFFFF_FFFF);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jr_align got %h want fffffffc", pc); end
    checks++; if (link_data !== 32'h0) begin errors++; $display("FAIL wrap_link_data got %h want 0", link_data); end
    fetch_issue(32'h0000_0000);
    exec_done = 1;
    cyc();
    idle();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h want 0", pc); end
  endtask
  task automatic test_jal;
    retire_jr(32'h0040_0010);
    fetch_issue(32'h0C00_0040);
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jal_pre_we got %0b want 0", link_we); end
    jump = 1; exec_done = 1;
    #1;
    checks++; if (link_we !== 1'b1) begin errors++; $display("FAIL jal_we got %0b want 1", link_we); end
    checks++; if (link_data !== 32'h0040_0014) begin errors++; $display("FAIL jal_link got %h want 00400014", link_data); end
    cyc();
    idle();
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jal_we_fall got %0b want 0", link_we); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL jal_target got %h want 00000100", bus.imem_addr); end
  endtask
  task automatic test_ignored;
    exec_done = 1;
    cyc();
    exec_done = 0;
    checks++; if (pc !== 32'h100 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL exec_in_fetch got pc %h req %0b want 00000100 1", pc, bus.imem_req); end
    fetch_issue(32'h1111_1111);
    bus.imem_ack = 1; bus.imem_rvalid = 1; bus.imem_rdata = 32'h2222_2222;
    cyc();
    bus.imem_ack = 0; bus.imem_rvalid = 0;
    checks++; if (ins !== 32'h1111_1111 || ins_valid !== 1'b1) begin errors++; $display("FAIL rvalid_in_issue got %h %0b want 11111111 1", ins, ins_valid); end
    exec_done = 1;
    cyc();
    idle();
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1; bus.imem_rvalid = 1; bus.imem_rdata = 32'hA000_0000 + i;
      cyc();
      bus.imem_ack = 0; bus.imem_rvalid = 0; exec_done = 1;
      checks++; if (ins !== 32'hA000_0000 + i || ins_valid !== 1'b1) begin errors++; $display("FAIL b2b_ins got %h %0b want %h 1", ins, ins_valid, 32'hA000_0000 + i); end
      cyc();
      exec_done = 0;
      checks++; if (pc !== 32'h108 + 4 * i || bus.imem_req !== 1'b1) begin errors++; $display("FAIL b2b_pc got %h req %0b want %h 1", pc, bus.imem_req, 32'h108 + 4 * i); end
    end
  endtask
  task automatic test_reset_mid;
    bus.imem_ack = 1;
    cyc();
    bus.imem_ack = 0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_wait_req got %0b want 0", bus.imem_req); end
    rst_n = 0;
    cyc();
    rst_n = 1; bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL mid_reset got req %0b pc %h want 1 00000100", bus.imem_req, pc); end
    cyc();
    bus.imem_rvalid = 0;
    checks++; if (ins_valid !== 1'b0 || ins !== 32'h0) begin errors++; $display("FAIL late_rvalid got %h %0b want 0 0", ins, ins_valid); end
    checks++; if (bus.imem_req !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL mid_refetch got req %0b pc %h want 1 00000100", bus.imem_req, pc); end
  endtask
  initial begin
    test_reset();
    test_seq_delay();
    test_jr_priority();
    test_bleu();
    test_jal();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
